counter_rr_scheduler: RTL and testbench

//   Time-shares one WIDTH-bit synchronous count engine among NREQ requesters.

---
 rtl/counter_sched_pkg.sv | 18 +
 rtl/rr_pick.sv | 43 ++++
 rtl/counter_rr_scheduler.sv | 102 ++++++++++
 tb/tb_counter_rr_scheduler.sv | 182 ++++++++++++++++++
 4 files changed

// File: rtl/counter_sched_pkg.sv
// Shared types for the round-robin count-engine scheduler.
// State encoding and the grant one-hot helper live here.
package counter_sched_pkg;

    localparam int STATE_W = 2;
    localparam int MAX_REQ = 16;

    typedef enum logic [STATE_W-1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    function automatic logic [MAX_REQ-1:0] onehot(input logic [3:0] idx);
        return MAX_REQ'(1) << idx;
    endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational winner search over the request vector.
// COUNTER_SCHED_FIXED_PRIO_EN selects fixed priority (bit 0 highest).
module rr_pick #(
    parameter int NREQ = 4,
    parameter int IW   = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] req,
    input  logic [IW-1:0]   ptr,
    output logic            valid,
    output logic [IW-1:0]   winner
);

`ifdef COUNTER_SCHED_FIXED_PRIO_EN
    logic unused_ptr;
    assign unused_ptr = ^ptr;

    always_comb begin
        valid  = |req;
        winner = '0;
        for (int i = NREQ - 1; i >= 0; i--) begin
            if (req[i]) winner = IW'(i);
        end
    end
`else
    always_comb begin
        int   idx;
        logic found;
        valid  = |req;
        winner = '0;
        found  = 1'b0;
        idx    = 0;
        // Search starts just past the last grantee and wraps.
        for (int i = 1; i <= NREQ; i++) begin
            idx = (int'(ptr) + i) % NREQ;
            if (!found && req[idx]) begin
                winner = IW'(idx);
                found  = 1'b1;
            end
        end
    end
`endif

endmodule

// File: rtl/counter_rr_scheduler.sv
// Shares one count engine among NREQ requesters with a one-hot grant.
// Build option COUNTER_SCHED_FIXED_PRIO_EN: fixed priority instead of RR.
module counter_rr_scheduler
    import counter_sched_pkg::*;
#(
    parameter int NREQ  = 4,
    parameter int WIDTH = 8
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [NREQ-1:0]           req,
    input  logic [NREQ*WIDTH-1:0]     len,
    output logic [NREQ-1:0]           gnt,
    output logic [$clog2(NREQ)-1:0]   owner,
    output logic [WIDTH-1:0]          cnt,
    output logic                      busy,
    output logic                      done,
    output logic                      abort
);

    localparam int IW = $clog2(NREQ);

    state_e             state;
    logic [WIDTH-1:0]   len_q;
    logic [IW-1:0]      ptr;
    logic               pick_v;
    logic [IW-1:0]      pick_w;
    logic [WIDTH-1:0]   len_w;
    logic [MAX_REQ-1:0] pick_oh;
    logic               unused_oh;

    rr_pick #(.NREQ(NREQ), .IW(IW)) u_pick (
        .req    (req),
        .ptr    (ptr),
        .valid  (pick_v),
        .winner (pick_w)
    );

    assign len_w     = len[pick_w*WIDTH +: WIDTH];
    assign pick_oh   = onehot(4'(pick_w));
    assign unused_oh = ^pick_oh;

    always_ff @(posedge clk) begin
        if (!reset) begin
            state <= IDLE;
            gnt   <= '0;
            owner <= '0;
            cnt   <= '0;
            busy  <= 1'b0;
            done  <= 1'b0;
            abort <= 1'b0;
            ptr   <= IW'(NREQ - 1);
            len_q <= '0;
        end else begin
            done  <= 1'b0;
            abort <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (pick_v) begin
                        len_q <= len_w;
                        gnt   <= NREQ'(pick_oh);
                        owner <= pick_w;
                        cnt   <= '0;
                        busy  <= 1'b1;
`ifndef COUNTER_SCHED_FIXED_PRIO_EN
                        ptr   <= pick_w;
`endif
                        // A zero-length run commits straight to done.
                        if (len_w == '0) begin
                            state <= DONE;
                            done  <= 1'b1;
                        end else begin
                            state <= RUN;
                        end
                    end
                end
                RUN: begin
                    if (!req[owner]) begin
                        state <= IDLE;
                        abort <= 1'b1;
                        gnt   <= '0;
                        busy  <= 1'b0;
                        cnt   <= '0;
                    end else if (cnt == len_q - WIDTH'(1)) begin
                        state <= DONE;
                        done  <= 1'b1;
                    end else begin
                        cnt <= cnt + WIDTH'(1);
                    end
                end
                DONE: begin
                    state <= IDLE;
                    gnt   <= '0;
                    busy  <= 1'b0;
                    cnt   <= '0;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_counter_rr_scheduler.sv
// Scoreboard bench: stimulus queues expected active cycles,
// a negedge monitor pops and compares whenever the block is active.
module tb_counter_rr_scheduler;

    localparam int NREQ  = 4;
    localparam int WIDTH = 8;

    typedef struct packed {
        logic [NREQ-1:0]  gnt;
        logic [WIDTH-1:0] cnt;
        logic             busy;
        logic             done;
        logic             abort;
    } obs_t;

    logic                  clk;
    logic                  reset;
    logic [NREQ-1:0]       req;
    logic [NREQ*WIDTH-1:0] len;
    logic [NREQ-1:0]       gnt;
    logic [1:0]            owner;
    logic [WIDTH-1:0]      cnt;
    logic                  busy;
    logic                  done;
    logic                  abort;

    int   errors = 0;
    int   checks = 0;
    obs_t q[$];

    counter_rr_scheduler #(.NREQ(NREQ), .WIDTH(WIDTH)) dut (
        .clk   (clk),
        .reset (reset),
        .req   (req),
        .len   (len),
        .gnt   (gnt),
        .owner (owner),
        .cnt   (cnt),
        .busy  (busy),
        .done  (done),
        .abort (abort)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        obs_t got;
        obs_t e;
        if (busy || abort || done) begin
            got = '{gnt: gnt, cnt: cnt, busy: busy, done: done, abort: abort};
            checks++;
            if (q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_output got=%h required=none", got);
            end else begin
                e = q.pop_front();
                if (got !== e) begin
                    errors++;
                    $display("FAIL active_cycle got=%h required=%h", got, e);
                end
            end
        end
    end

    task automatic push(input logic [NREQ-1:0] g, input logic [WIDTH-1:0] c,
                        input logic b, input logic d, input logic a);
        q.push_back('{gnt: g, cnt: c, busy: b, done: d, abort: a});
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_idle(input string name);
        logic [NREQ+2+WIDTH+2:0] v;
        v = {gnt, owner, cnt, busy, done, abort};
        checks++;
        if (v !== '0) begin
            errors++;
            $display("FAIL %s got=%h required=0", name, v);
        end
    endtask

    task automatic run(input int w, input int n);
        req = NREQ'(1) << w;
        len[w*WIDTH +: WIDTH] = WIDTH'(n);
        for (int c = 0; c < n; c++) push(NREQ'(1) << w, WIDTH'(c), 1, 0, 0);
        push(NREQ'(1) << w, (n == 0) ? '0 : WIDTH'(n - 1), 1, 1, 0);
        step();
        len[w*WIDTH +: WIDTH] = 8'hff;
        repeat (n) step();
        req = '0;
        repeat (2) step();
    endtask

    int order[5];

    initial begin
        reset = 1'b0;
        req   = '0;
        len   = '0;
        for (int i = 0; i < 3; i++) begin
            req = NREQ'($urandom);
            len = $urandom;
            @(negedge clk);
            if (i > 0) check_idle("reset_hold");
            @(posedge clk);
        end
        @(negedge clk);
        check_idle("reset_hold");
        req   = '0;
        reset = 1'b1;
        repeat (3) step();
        check_idle("idle_no_req");

        run(0, 5);

        reset = 1'b0;
        step();
        reset = 1'b1;
`ifdef COUNTER_SCHED_FIXED_PRIO_EN
        order = '{0, 0, 0, 0, 0};
`else
        order = '{0, 1, 2, 3, 0};
`endif
        req = 4'hf;
        len = {4{8'd2}};
        for (int k = 0; k < 5; k++) begin
            push(NREQ'(1) << order[k], 8'd0, 1, 0, 0);
            push(NREQ'(1) << order[k], 8'd1, 1, 0, 0);
            push(NREQ'(1) << order[k], 8'd1, 1, 1, 0);
        end
        repeat (19) step();
        req = '0;
        repeat (2) step();

        run(1, 0);

        req = 4'b0100;
        len[2*WIDTH +: WIDTH] = 8'd10;
        for (int c = 0; c < 4; c++) push(4'b0100, WIDTH'(c), 1, 0, 0);
        push(4'b0000, 8'd0, 0, 0, 1);
        step();
        repeat (3) step();
        req = '0;
        repeat (3) step();

        req = 4'b0001;
        len[0 +: WIDTH] = 8'd20;
        for (int c = 0; c < 7; c++) push(4'b0001, WIDTH'(c), 1, 0, 0);
        step();
        repeat (6) step();
        reset = 1'b0;
        step();
        @(negedge clk);
        check_idle("reset_mid_run");
        reset = 1'b1;
        req   = 4'b0011;
        len[0 +: 2*WIDTH] = {8'd1, 8'd1};
        push(4'b0001, 8'd0, 1, 0, 0);
        push(4'b0001, 8'd0, 1, 1, 0);
        step();
        step();
        req = '0;
        repeat (2) step();

        for (int i = 0; i < 50 && q.size() != 0; i++) step();
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL drain got=%0d required=0 pending", q.size());
        end
        @(negedge clk);
        check_idle("final_idle");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
